// File: rtl/compare_search_sar.sv
// ---------------------------------------------------------------------------
// compare_search_sar
// Successive-approximation search controller. It drives the B side of an
// external magnitude comparator and resolves the unknown A value one bit per
// trial, MSB first. It exits early when the comparator reports equality.
//
// Ports
//   Clock_In       rising-edge clock
//   Reset_In       synchronous, active-high reset
//   Start_In       begin a search (honoured only while idle)
//   Enable_Out     comparator enable, high during the DRIVE and SAMPLE states
//   Candidate_Out  trial value presented to the comparator B input
//   A_gt_B_In      comparator response: target >  candidate
//   A_eq_B_In      comparator response: target == candidate
//   A_lt_B_In      comparator response: target <  candidate
//   Busy_Out       high in the DRIVE, SAMPLE and DONE states
//   Done_Out       one-cycle pulse when Result_Out/Error_Out are valid
//   Result_Out     resolved target, held until the next accepted start
//   Error_Out      the comparator response was not one-hot; held with result
// ---------------------------------------------------------------------------
module compare_search_sar #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Start_In,
    output logic             Enable_Out,
    output logic [WIDTH-1:0] Candidate_Out,
    input  logic             A_gt_B_In,
    input  logic             A_eq_B_In,
    input  logic             A_lt_B_In,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Result_Out,
    output logic             Error_Out
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [IW-1:0]    r_idx;

    logic [2:0]       w_flags;
    logic [WIDTH-1:0] w_acc_next;
    logic [IW-1:0]    w_idx_next;
    logic [WIDTH-1:0] w_cand_next;

    // The flags are packed as {gt, eq, lt}. Only the three one-hot codes are legal.
    assign w_flags     = {A_gt_B_In, A_eq_B_In, A_lt_B_In};
    // On gt, keep the trial bit. On lt, drop it (the accumulator is unchanged).
    assign w_acc_next  = (w_flags == 3'b100) ? Candidate_Out : r_acc;
    assign w_idx_next  = r_idx - IW'(1);
    assign w_cand_next = w_acc_next | (WIDTH'(1) << w_idx_next);

    // Search sequencer with registered outputs.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_idx         <= IW'(WIDTH - 1);
            Enable_Out    <= 1'b0;
            Candidate_Out <= '0;
            Busy_Out      <= 1'b0;
            Done_Out      <= 1'b0;
            Result_Out    <= '0;
            Error_Out     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start_In) begin
                        r_acc         <= '0;
                        r_idx         <= IW'(WIDTH - 1);
                        Candidate_Out <= WIDTH'(1) << (WIDTH - 1);
                        Result_Out    <= '0;
                        Error_Out     <= 1'b0;
                        Enable_Out    <= 1'b1;
                        Busy_Out      <= 1'b1;
                        r_state       <= S_DRIVE;
                    end
                end

                // The comparator settles on the candidate for one cycle.
                S_DRIVE: begin
                    r_state <= S_SAMPLE;
                end

                S_SAMPLE: begin
                    case (w_flags)
                        3'b010: begin
                            Result_Out <= Candidate_Out;
                            Enable_Out <= 1'b0;
                            Done_Out   <= 1'b1;
                            r_state    <= S_DONE;
                        end
                        3'b100, 3'b001: begin
                            r_acc <= w_acc_next;
                            if (r_idx == '0) begin
                                Result_Out <= w_acc_next;
                                Enable_Out <= 1'b0;
                                Done_Out   <= 1'b1;
                                r_state    <= S_DONE;
                            end else begin
                                r_idx         <= w_idx_next;
                                Candidate_Out <= w_cand_next;
                                r_state       <= S_DRIVE;
                            end
                        end
                        // Zero, multiple, or unknown flags: abort with an error.
                        default: begin
                            Error_Out  <= 1'b1;
                            Result_Out <= '0;
                            Enable_Out <= 1'b0;
                            Done_Out   <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    endcase
                end

                S_DONE: begin
                    Done_Out <= 1'b0;
                    Busy_Out <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_search_sar.sv
// ---------------------------------------------------------------------------
// tb_compare_search_sar
// Directed bench for compare_search_sar. The bench models the comparator
// behaviourally on A = target and B = Candidate_Out. Per-cycle expectations
// come from a plain binary-search model of each run.
// ---------------------------------------------------------------------------
module tb_compare_search_sar;

    localparam int unsigned W  = 8;
    localparam int          NC = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         en;
    logic [W-1:0] cand;
    logic         gt, eq, lt;
    logic         busy, done, err;
    logic [W-1:0] res;

    logic [W-1:0] target;
    logic         fault;

    int n_chk = 0;
    int n_err = 0;

    compare_search_sar #(.WIDTH(W)) dut (
        .Clock_In      (clk),
        .Reset_In      (rst),
        .Start_In      (start),
        .Enable_Out    (en),
        .Candidate_Out (cand),
        .A_gt_B_In     (gt),
        .A_eq_B_In     (eq),
        .A_lt_B_In     (lt),
        .Busy_Out      (busy),
        .Done_Out      (done),
        .Result_Out    (res),
        .Error_Out     (err)
    );

    always #5 clk = ~clk;

    // The comparator outputs are tristated (unknown) while disabled. A fault forces gt=eq=1.
    assign gt = !en ? 1'bx : fault ? 1'b1 : (target >  cand);
    assign eq = !en ? 1'bx : fault ? 1'b1 : (target == cand);
    assign lt = !en ? 1'bx : fault ? 1'b0 : (target <  cand);

    // Expected outputs per cycle. Cycle 0 is the cycle in which Start is sampled.
    logic [W-1:0] m_cand  [0:NC-1];
    bit           m_cand_v[0:NC-1];
    bit           m_en    [0:NC-1];
    bit           m_busy  [0:NC-1];
    bit           m_done  [0:NC-1];
    logic [W-1:0] m_res   [0:NC-1];
    bit           m_err   [0:NC-1];
    int           m_last;
    int           m_done_cyc;
    logic [W-1:0] m_result;
    bit           m_error;

    task automatic chk(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, act, exp);
        end
    endtask

    // Binary search on the target: keep the trial bit when target > trial.
    // A fault at trial k yields an error at that trial. An abort cycle zeroes everything after it.
    task automatic build_model(input logic [W-1:0] tgt, input int fault_trial,
                               input int abort_cyc);
        logic [W-1:0] acc;
        logic [W-1:0] tr;
        int           dc;
        int           b;
        acc = '0; dc = 0; m_result = '0; m_error = 1'b0;
        for (int c = 0; c < NC; c++) begin
            m_cand[c] = '0; m_cand_v[c] = 1'b0; m_en[c] = 1'b0; m_busy[c] = 1'b0;
            m_done[c] = 1'b0; m_res[c] = '0; m_err[c] = 1'b0;
        end
        for (int k = 1; k <= int'(W) && dc == 0; k++) begin
            b  = int'(W) - k;
            tr = acc | (W'(1) << b);
            for (int c = 2*k-1; c <= 2*k; c++) begin
                m_cand[c] = tr; m_cand_v[c] = 1'b1; m_en[c] = 1'b1; m_busy[c] = 1'b1;
            end
            if (k == fault_trial) begin
                m_error = 1'b1; m_result = '0; dc = 2*k+1;
            end else if (tr == tgt) begin
                m_result = tr; dc = 2*k+1;
            end else begin
                if (tgt > tr) acc = tr;
                if (b == 0) begin
                    m_result = acc; dc = 2*k+1;
                end
            end
        end
        m_done_cyc  = dc;
        m_busy[dc]  = 1'b1;
        m_done[dc]  = 1'b1;
        for (int c = dc; c < NC; c++) begin
            m_res[c] = m_result; m_err[c] = m_error;
        end
        m_last = dc + 1;
        if (abort_cyc > 0) begin
            for (int c = abort_cyc + 1; c < NC; c++) begin
                m_cand[c] = '0; m_cand_v[c] = 1'b1; m_en[c] = 1'b0; m_busy[c] = 1'b0;
                m_done[c] = 1'b0; m_res[c] = '0; m_err[c] = 1'b0;
            end
            m_last = abort_cyc + 14;
        end
    endtask

    bit active = 1'b0;
    int cyc    = 1;

    // Compare process: check every output against the model once per cycle.
    always @(negedge clk) begin
        if (!active) begin
            cyc = 1;
        end else begin
            if (cyc <= m_last) begin
                chk("enable", cyc, 32'(en),   32'(m_en[cyc]));
                chk("busy",   cyc, 32'(busy), 32'(m_busy[cyc]));
                chk("done",   cyc, 32'(done), 32'(m_done[cyc]));
                chk("result", cyc, 32'(res),  32'(m_res[cyc]));
                chk("error",  cyc, 32'(err),  32'(m_err[cyc]));
                if (m_cand_v[cyc]) chk("candidate", cyc, 32'(cand), 32'(m_cand[cyc]));
            end
            cyc++;
        end
    end

    task automatic run_search(input logic [W-1:0] tgt, input int fault_trial,
                              input int abort_cyc, input bit stray_starts);
        int guard;
        target = tgt;
        build_model(tgt, fault_trial, abort_cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        active = 1'b1;
        guard  = 0;
        while (cyc <= m_last && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            if (stray_starts)    start = (cyc == 3 || cyc == 5);
            if (fault_trial > 0) fault = (cyc == 2*fault_trial);
            if (abort_cyc > 0)   rst   = (cyc == abort_cyc);
        end
        start = 1'b0; fault = 1'b0; rst = 1'b0;
        chk("run_bounded", guard, 32'(guard < 100), 32'd1);
        @(negedge clk);
        active = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fault = 1'b0; target = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_enable", 0, 32'(en),   32'd0);
        chk("rst_cand",   0, 32'(cand), 32'd0);
        chk("rst_busy",   0, 32'(busy), 32'd0);
        chk("rst_done",   0, 32'(done), 32'd0);
        chk("rst_result", 0, 32'(res),  32'd0);
        chk("rst_error",  0, 32'(err),  32'd0);

        run_search(8'h80, 0, 0, 1'b0);
        chk("pin80_done_cyc", 0, 32'(m_done_cyc), 32'd3);
        chk("pin80_result",   0, 32'(m_result),   32'h80);

        run_search(8'h00, 0, 0, 1'b0);
        chk("pin00_done_cyc", 0, 32'(m_done_cyc), 32'd17);
        chk("pin00_cand_t8",  0, 32'(m_cand[15]), 32'h01);

        run_search(8'hFF, 0, 0, 1'b0);
        chk("pinFF_done_cyc", 0, 32'(m_done_cyc), 32'd17);
        chk("pinFF_result",   0, 32'(m_result),   32'hFF);

        run_search(8'h5A, 0, 0, 1'b0);
        chk("pin5A_done_cyc", 0, 32'(m_done_cyc), 32'd15);
        chk("pin5A_cand_t3",  0, 32'(m_cand[5]),  32'h60);
        chk("pin5A_cand_t6",  0, 32'(m_cand[11]), 32'h5C);
        chk("pin5A_cand_t7",  0, 32'(m_cand[13]), 32'h5A);

        run_search(8'h5A, 3, 0, 1'b0);
        chk("pinflt_done_cyc", 0, 32'(m_done_cyc), 32'd7);
        chk("pinflt_error",    0, 32'(m_error),    32'd1);

        // A clean start after the fault must clear Error_Out.
        run_search(8'h5A, 0, 0, 1'b1);
        run_search(8'h5A, 0, 6, 1'b0);
        run_search(8'h5A, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
